// File: rtl/multiport_regfile_if.sv
// Bus bundle for multiport_regfile: read ports, write-back ports and the
// issue/scoreboard handshake. The master drives requests; the register file is the slave.
interface multiport_regfile_if #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
) ();
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);

    logic                   rd_en;
    logic [NREAD*AW-1:0]    rd_addr;
    logic [NREAD*XLEN-1:0]  rd_data;
    logic [NREAD-1:0]       rd_busy;

    logic [NWRITE-1:0]      wr_en;
    logic [NWRITE*AW-1:0]   wr_addr;
    logic [NWRITE*XLEN-1:0] wr_data;

    logic                   iss_en;
    logic [AW-1:0]          iss_addr;
    logic                   iss_ready;
    logic [CW-1:0]          busy_cnt;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, iss_ready, busy_cnt
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, iss_ready, busy_cnt
    );
endinterface

// File: rtl/multiport_regfile.sv
// Multi-port register file with a per-register pending-write scoreboard (x0 hardwired to zero).
// Define MULTIPORT_REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module multiport_regfile #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    multiport_regfile_if.slave   bus
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [CW-1:0]    r_busyCnt;

    logic [AW-1:0]     w_wrAddr [NWRITE];
    logic [XLEN-1:0]   w_wrData [NWRITE];
    logic [NWRITE-1:0] w_wrValid;
    logic [AW-1:0]     w_rdAddr [NREAD];
    logic [NREGS-1:0]  w_busyNext;
    logic              w_issReady;
    logic              w_issFire;

    function automatic logic [CW-1:0] popCount(input logic [NREGS-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NREGS; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // A write port only counts when enabled and not aimed at the hardwired zero register.
    always_comb begin
        for (int p = 0; p < NWRITE; p++) begin
            w_wrAddr[p]  = bus.wr_addr[p*AW +: AW];
            w_wrData[p]  = bus.wr_data[p*XLEN +: XLEN];
            w_wrValid[p] = bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] != '0);
        end
        for (int i = 0; i < NREAD; i++) begin
            w_rdAddr[i] = bus.rd_addr[i*AW +: AW];
        end
    end

    // Port order gives priority: the highest-numbered port's assignment lands last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NWRITE; p++) begin
                if (w_wrValid[p]) begin
                    r_regs[w_wrAddr[p]] <= w_wrData[p];
                end
            end
        end
    end

    assign w_issReady = (bus.iss_addr == '0) || !r_busy[bus.iss_addr];
    assign w_issFire  = bus.iss_en && w_issReady && (bus.iss_addr != '0);

    // Write-back clears first so a same-cycle issue to that register leaves it pending.
    always_comb begin
        w_busyNext = r_busy;
        for (int p = 0; p < NWRITE; p++) begin
            if (w_wrValid[p]) begin
                w_busyNext[w_wrAddr[p]] = 1'b0;
            end
        end
        if (w_issFire) begin
            w_busyNext[bus.iss_addr] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= '0;
            r_busyCnt <= '0;
        end else begin
            r_busy    <= w_busyNext;
            r_busyCnt <= popCount(w_busyNext);
        end
    end

    assign bus.iss_ready = w_issReady;
    assign bus.busy_cnt  = r_busyCnt;

`ifdef MULTIPORT_REGFILE_BYPASS_EN
    logic [NREAD-1:0] w_fwdHit;
    logic [XLEN-1:0]  w_fwdData [NREAD];

    // Forwarding is suppressed during reset so reads stay zero while rst is high.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            w_fwdHit[i]  = 1'b0;
            w_fwdData[i] = '0;
            for (int p = 0; p < NWRITE; p++) begin
                if (!rst && w_wrValid[p] && (w_wrAddr[p] == w_rdAddr[i])) begin
                    w_fwdHit[i]  = 1'b1;
                    w_fwdData[i] = w_wrData[p];
                end
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (bus.rd_en && (w_rdAddr[i] != '0)) begin
                if (w_fwdHit[i]) begin
                    bus.rd_data[i*XLEN +: XLEN] = w_fwdData[i];
                end else begin
                    bus.rd_data[i*XLEN +: XLEN] = r_regs[w_rdAddr[i]];
                    bus.rd_busy[i]              = r_busy[w_rdAddr[i]];
                end
            end
        end
    end
`else
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (bus.rd_en && (w_rdAddr[i] != '0)) begin
                bus.rd_data[i*XLEN +: XLEN] = r_regs[w_rdAddr[i]];
                bus.rd_busy[i]              = r_busy[w_rdAddr[i]];
            end
        end
    end
`endif

endmodule

// File: tb/tb_multiport_regfile.sv
// Scoreboard bench for multiport_regfile: a behavioural register-file/pending-set model
// predicts each cycle's outputs, and a negedge monitor pops and compares them.
module tb_multiport_regfile;
    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;
    localparam int AW     = $clog2(NREGS);
    localparam int CW     = $clog2(NREGS + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    multiport_regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE)) bus ();

    multiport_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string                 tag;
        logic [NREAD*XLEN-1:0] data;
        logic [NREAD-1:0]      busy;
        logic                  rdy;
        logic [CW-1:0]         cnt;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    logic [XLEN-1:0] mdlMem [NREGS];
    bit              mdlPend [int];

    task automatic modelReset();
        for (int r = 0; r < NREGS; r++) mdlMem[r] = '0;
        mdlPend.delete();
    endtask

    function automatic logic [2*AW-1:0] pa(input int a0, input int a1);
        return {AW'(a1), AW'(a0)};
    endfunction

    function automatic logic [2*XLEN-1:0] pd(input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1);
        return {d1, d0};
    endfunction

    // Drive one cycle, predict outputs from the model, then advance the model past the edge.
    task automatic applyStimulus(input string tag, input logic rdEn, input logic [NREAD*AW-1:0] rdA,
                                 input logic [NWRITE-1:0] wrEn, input logic [NWRITE*AW-1:0] wrA,
                                 input logic [NWRITE*XLEN-1:0] wrD, input logic issEn,
                                 input logic [AW-1:0] issA);
        exp_t e;
        int   a;
        int   wa;
        bit   b;
        logic [XLEN-1:0] d;
        bus.rd_en    = rdEn;
        bus.rd_addr  = rdA;
        bus.wr_en    = wrEn;
        bus.wr_addr  = wrA;
        bus.wr_data  = wrD;
        bus.iss_en   = issEn;
        bus.iss_addr = issA;

        e.tag  = tag;
        e.data = '0;
        e.busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            a = int'(rdA[i*AW +: AW]);
            d = '0;
            b = 1'b0;
            if (!rst && rdEn && a != 0) begin
                d = mdlMem[a];
                b = mdlPend.exists(a);
`ifdef MULTIPORT_REGFILE_BYPASS_EN
                for (int p = 0; p < NWRITE; p++) begin
                    if (wrEn[p] && int'(wrA[p*AW +: AW]) == a) begin
                        d = wrD[p*XLEN +: XLEN];
                        b = 1'b0;
                    end
                end
`endif
            end
            e.data[i*XLEN +: XLEN] = d;
            e.busy[i] = b;
        end
        e.rdy = (issA == '0) || !mdlPend.exists(int'(issA));
        e.cnt = CW'(mdlPend.num());
        sbQ.push_back(e);

        @(posedge clk);
        #1;
        if (!rst) begin
            for (int p = 0; p < NWRITE; p++) begin
                wa = int'(wrA[p*AW +: AW]);
                if (wrEn[p] && wa != 0) begin
                    mdlMem[wa] = wrD[p*XLEN +: XLEN];
                    if (mdlPend.exists(wa)) mdlPend.delete(wa);
                end
            end
            if (issEn && e.rdy && issA != '0) mdlPend[int'(issA)] = 1'b1;
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (bus.rd_data !== e.data) begin
            errors++;
            $display("[TB] FAIL %s rd_data got %h expected %h", e.tag, bus.rd_data, e.data);
        end
        checks++;
        if (bus.rd_busy !== e.busy) begin
            errors++;
            $display("[TB] FAIL %s rd_busy got %b expected %b", e.tag, bus.rd_busy, e.busy);
        end
        checks++;
        if (bus.iss_ready !== e.rdy) begin
            errors++;
            $display("[TB] FAIL %s iss_ready got %b expected %b", e.tag, bus.iss_ready, e.rdy);
        end
        checks++;
        if (bus.busy_cnt !== e.cnt) begin
            errors++;
            $display("[TB] FAIL %s busy_cnt got %0d expected %0d", e.tag, bus.busy_cnt, e.cnt);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        modelReset();
        @(posedge clk);
        #1;

        applyStimulus("rst_state", 1, pa(5, 6), 2'b11, pa(5, 6), pd(32'h1, 32'h2), 1, 5'd7);
        rst = 1'b0;
        applyStimulus("rst_discard", 1, pa(5, 6), 2'b00, '0, '0, 0, 5'd7);

        applyStimulus("wr_x5_iss_x7", 1, pa(5, 7), 2'b01, pa(5, 0), pd(32'hDEADBEEF, 0), 1, 5'd7);
        applyStimulus("rd_x5_x7", 1, pa(5, 7), 2'b00, '0, '0, 0, 5'd7);
        rst = 1'b1;
        modelReset();
        applyStimulus("async_rst", 1, pa(5, 7), 2'b00, '0, '0, 1, 5'd7);
        rst = 1'b0;
        applyStimulus("iss_x7_after_rst", 1, pa(5, 7), 2'b00, '0, '0, 1, 5'd7);
        applyStimulus("reiss_x7_stall", 1, pa(7, 5), 2'b00, '0, '0, 1, 5'd7);

        applyStimulus("wr_conflict_x3", 0, pa(3, 3), 2'b11, pa(3, 3), pd(32'h11, 32'h22), 0, 5'd0);
        applyStimulus("rd_x3", 1, pa(3, 0), 2'b00, '0, '0, 0, 5'd0);

        applyStimulus("iss_x9", 1, pa(9, 0), 2'b00, '0, '0, 1, 5'd9);
        applyStimulus("reiss_x9", 1, pa(9, 0), 2'b00, '0, '0, 1, 5'd9);
        applyStimulus("wr_x9", 0, pa(9, 0), 2'b10, pa(0, 9), pd(0, 32'h5), 0, 5'd0);
        applyStimulus("rd_x9", 1, pa(0, 9), 2'b00, '0, '0, 1, 5'd9);

        applyStimulus("wr_x4_old", 0, '0, 2'b01, pa(4, 0), pd(32'h1234, 0), 0, 5'd0);
        applyStimulus("iss_x4", 0, '0, 2'b00, '0, '0, 1, 5'd4);
        applyStimulus("bypass_x4", 1, pa(4, 4), 2'b01, pa(4, 0), pd(32'hCAFE, 0), 0, 5'd0);
        applyStimulus("rd_x4", 1, pa(4, 0), 2'b00, '0, '0, 0, 5'd0);

        applyStimulus("x0_wr_iss", 1, pa(0, 0), 2'b11, pa(0, 0), pd(32'hFFFF, 32'hFFFF), 1, 5'd0);
        applyStimulus("x0_rd", 1, pa(0, 0), 2'b00, '0, '0, 1, 5'd0);

        applyStimulus("iss_wr_x12", 1, pa(12, 0), 2'b01, pa(12, 0), pd(32'h7, 0), 1, 5'd12);
        applyStimulus("rd_x12", 1, pa(12, 0), 2'b00, '0, '0, 0, 5'd0);
        applyStimulus("rd_en_low", 0, pa(12, 7), 2'b00, '0, '0, 0, 5'd0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                modelReset();
            end else begin
                rst = 1'b0;
            end
            applyStimulus("random", ($urandom_range(0, 7) != 0),
                          pa($urandom_range(0, 15), $urandom_range(0, 15)),
                          NWRITE'($urandom_range(0, 3)),
                          pa($urandom_range(0, 15), $urandom_range(0, 15)),
                          pd($urandom, $urandom),
                          ($urandom_range(0, 2) != 0),
                          AW'($urandom_range(0, 15)));
        end
        rst = 1'b0;

        for (int k = 0; k < 5 && sbQ.size() > 0; k++) @(negedge clk);
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending %0d expected 0", sbQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, minimum 2.
REQ-003 SHALL have parameter NREAD, default 2, number of read ports, range 1..4.
REQ-004 SHALL have parameter NWRITE, default 2, number of write ports, range 1..2.
REQ-005 SHALL derive AW = clog2(NREGS) and CW = clog2(NREGS+1).
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 rd_en  in  1  read enable, shared by all read ports.
REQ-009 rd_addr  in  NREAD*AW  read addresses; port i at bits [i*AW +: AW].
REQ-010 rd_data  out  NREAD*XLEN  read data, packed the same way.
REQ-011 rd_busy  out  NREAD  per read port: addressed register has a pending write.
REQ-012 wr_en  in  NWRITE  per-port write enable.
REQ-013 wr_addr  in  NWRITE*AW  write addresses.
REQ-014 wr_data  in  NWRITE*XLEN  write data.
REQ-015 iss_en  in  1  issue request; marks iss_addr pending.
REQ-016 iss_addr  in  AW  issue destination register.
REQ-017 iss_ready  out  1  issue accepted this cycle.
REQ-018 busy_cnt  out  CW  number of registers currently pending.

Function
REQ-019 Register 0 SHALL read 0 and never be busy; writes and issues to address 0 SHALL be ignored.
REQ-020 Writes SHALL commit on the rising edge where wr_en[p] is 1; reads SHALL be combinational, zero-latency.
REQ-021 Two write ports to the same nonzero address in one cycle: port NWRITE-1 data SHALL win.
REQ-022 rd_en=0 SHALL force every rd_data lane and every rd_busy bit to 0.
REQ-023 iss_ready SHALL be 1 when iss_addr is 0 or busy[iss_addr]=0; it SHALL be 0 otherwise (WAW stall), regardless of same-cycle writeback.
REQ-024 iss_en & iss_ready & iss_addr!=0 SHALL set busy[iss_addr] at the next edge.
REQ-025 Any wr_en[p] to a nonzero address SHALL clear busy[wr_addr[p]] at the next edge.
REQ-026 Issue and write to the same register in one cycle: data SHALL commit and busy SHALL end set (set wins).
REQ-027 busy_cnt SHALL be a register equal to the population count of busy bits after every edge; it SHALL never exceed NREGS-1.
REQ-028 Writes to non-busy registers SHALL be legal and SHALL leave busy_cnt unchanged.

Reset
REQ-029 rst=1 SHALL asynchronously clear all registers to 0, all busy bits to 0, and busy_cnt to 0.
REQ-030 During reset, iss_ready SHALL be 1, rd_data SHALL be 0, and rd_busy SHALL be 0.
REQ-031 Writes or issues presented while rst=1 SHALL be discarded; state SHALL update from the first edge after deassertion.

Configuration
REQ-032 Macro MULTIPORT_REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-033 Defined: a read of a nonzero address being written this cycle SHALL return that write's wr_data (REQ-021 priority) with rd_busy=0.
REQ-034 Undefined: reads SHALL return stored contents only; rd_busy SHALL reflect current busy state; no combinational path from wr_* to rd_*.

Verification
REQ-035 Reset mid-run: write x5=0xDEADBEEF, issue x7, assert rst -> rd x5=0, busy_cnt=0, iss_ready=1 without waiting for an edge.
REQ-036 Port conflict: wr0 x3=0x11 and wr1 x3=0x22 in the same cycle -> next cycle rd x3=0x22.
REQ-037 Scoreboard: issue x9 -> busy_cnt=1, re-issue x9 gives iss_ready=0; wr x9=0x5 -> busy_cnt=0, rd_busy=0, rd x9=0x5.
REQ-038 Bypass: x4 busy, write x4=0xCAFE while reading x4 -> with macro rd_data=0xCAFE, rd_busy=0; without macro rd_data=old value, rd_busy=1.
REQ-039 x0: write x0=0xFFFF and issue x0 -> rd x0=0, iss_ready=1, busy_cnt unchanged.
REQ-040 Issue and write x12=0x7 in the same cycle -> rd x12=0x7, rd_busy=1, busy_cnt +1.
